// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-synchronises to a Fibonacci LFSR stream, locks, then counts bit errors.
// Optional PRBS_CHK_STATS_EN adds bit_cnt, the saturating count of beats compared while locked.
module prbs_checker #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] TAPS        = 4'b1100,
  parameter int               LOCK_CNT    = 8,
  parameter int               UNLOCK_ERRS = 4,
  parameter int               GOOD_RUN    = 16,
  parameter int               ERR_W       = 16
) (
  input  logic             clk,
  input  logic             RSTn,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic             lock_lost,
  output logic [ERR_W-1:0] err_cnt
`ifdef PRBS_CHK_STATS_EN
  ,
  output logic [31:0]      bit_cnt
`endif
);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  localparam int               LC_W        = $clog2(WIDTH);
  localparam logic [LC_W-1:0]  LOAD_LAST   = LC_W'(WIDTH - 1);
  localparam logic [7:0]       LOCK_LAST   = 8'(LOCK_CNT - 1);
  localparam logic [7:0]       GOOD_LAST   = 8'(GOOD_RUN - 1);
  localparam logic [3:0]       UNLOCK_LAST = 4'(UNLOCK_ERRS - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sr_reg, sr_next;
  logic [LC_W-1:0]  load_cnt_reg, load_cnt_next;
  logic [7:0]       match_cnt_reg, match_cnt_next;
  logic [7:0]       good_cnt_reg, good_cnt_next;
  logic [3:0]       tally_reg, tally_next;
  logic [ERR_W-1:0] err_cnt_reg, err_cnt_next;
  logic             locked_reg, locked_next;
  logic             err_pulse_reg, err_pulse_next;
  logic             lock_lost_reg, lock_lost_next;

  logic             pred;
  logic [WIDTH-1:0] shifted_in;

  assign pred       = ^(sr_reg & TAPS);
  assign shifted_in = {sr_reg[WIDTH-2:0], in_bit};

  always_comb begin
    state_next     = state_reg;
    sr_next        = sr_reg;
    load_cnt_next  = load_cnt_reg;
    match_cnt_next = match_cnt_reg;
    good_cnt_next  = good_cnt_reg;
    tally_next     = tally_reg;
    err_cnt_next   = err_cnt_reg;
    locked_next    = locked_reg;
    err_pulse_next = 1'b0;
    lock_lost_next = 1'b0;

    if (in_valid) begin
      case (state_reg)
        SEARCH: begin
          sr_next = shifted_in;
          // Once loaded, keep sliding until the window is non-zero; all-zero is the LFSR lock-up state.
          if (load_cnt_reg == LOAD_LAST) begin
            if (|shifted_in) begin
              state_next     = VERIFY;
              match_cnt_next = '0;
            end
          end else begin
            load_cnt_next = load_cnt_reg + 1'b1;
          end
        end
        VERIFY: begin
          sr_next = shifted_in;
          if (pred == in_bit) begin
            if (match_cnt_reg == LOCK_LAST) begin
              state_next     = LOCKED;
              locked_next    = 1'b1;
              match_cnt_next = '0;
              good_cnt_next  = '0;
              tally_next     = '0;
            end else begin
              match_cnt_next = match_cnt_reg + 1'b1;
            end
          end else begin
            state_next     = SEARCH;
            match_cnt_next = '0;
            load_cnt_next  = '0;
          end
        end
        LOCKED: begin
          // Free-running on the prediction keeps a single flipped bit from causing a second error.
          sr_next = {sr_reg[WIDTH-2:0], pred};
          if (pred != in_bit) begin
            err_pulse_next = 1'b1;
            good_cnt_next  = '0;
            if (err_cnt_reg != {ERR_W{1'b1}}) begin
              err_cnt_next = err_cnt_reg + 1'b1;
            end
            if (tally_reg == UNLOCK_LAST) begin
              state_next     = SEARCH;
              locked_next    = 1'b0;
              lock_lost_next = 1'b1;
              tally_next     = '0;
              load_cnt_next  = '0;
            end else begin
              tally_next = tally_reg + 1'b1;
            end
          end else if (good_cnt_reg == GOOD_LAST) begin
            good_cnt_next = '0;
            tally_next    = '0;
          end else begin
            good_cnt_next = good_cnt_reg + 1'b1;
          end
        end
        default: state_next = SEARCH;
      endcase
    end

    if (clr_err) begin
      err_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_reg     <= SEARCH;
      sr_reg        <= '0;
      load_cnt_reg  <= '0;
      match_cnt_reg <= '0;
      good_cnt_reg  <= '0;
      tally_reg     <= '0;
      err_cnt_reg   <= '0;
      locked_reg    <= 1'b0;
      err_pulse_reg <= 1'b0;
      lock_lost_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sr_reg        <= sr_next;
      load_cnt_reg  <= load_cnt_next;
      match_cnt_reg <= match_cnt_next;
      good_cnt_reg  <= good_cnt_next;
      tally_reg     <= tally_next;
      err_cnt_reg   <= err_cnt_next;
      locked_reg    <= locked_next;
      err_pulse_reg <= err_pulse_next;
      lock_lost_reg <= lock_lost_next;
    end
  end

  assign locked    = locked_reg;
  assign err_pulse = err_pulse_reg;
  assign lock_lost = lock_lost_reg;
  assign err_cnt   = err_cnt_reg;

`ifdef PRBS_CHK_STATS_EN
  logic [31:0] bit_cnt_reg, bit_cnt_next;

  always_comb begin
    bit_cnt_next = bit_cnt_reg;
    if (in_valid && (state_reg == LOCKED) && (bit_cnt_reg != 32'hFFFF_FFFF)) begin
      bit_cnt_next = bit_cnt_reg + 32'd1;
    end
    if (clr_err) begin
      bit_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      bit_cnt_reg <= '0;
    end else begin
      bit_cnt_reg <= bit_cnt_next;
    end
  end

  assign bit_cnt = bit_cnt_reg;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: segment table, random stream against a bit-history model,
// and a saturating-counter sequence on a second instance with ERR_W=4.
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        RSTn = 1'b1;
  logic        in_valid = 1'b0, in_bit = 1'b0, clr_err = 1'b0;
  logic        locked, err_pulse, lock_lost;
  logic [15:0] err_cnt;
  logic        in_valid6 = 1'b0, in_bit6 = 1'b0, clr_err6 = 1'b0;
  logic        locked6, err_pulse6, lock_lost6;
  logic [3:0]  err_cnt6;
`ifdef PRBS_CHK_STATS_EN
  logic [31:0] bit_cnt, bit_cnt6;
`endif

  prbs_checker dut (
    .clk(clk), .RSTn(RSTn), .in_valid(in_valid), .in_bit(in_bit), .clr_err(clr_err),
    .locked(locked), .err_pulse(err_pulse), .lock_lost(lock_lost), .err_cnt(err_cnt)
`ifdef PRBS_CHK_STATS_EN
    , .bit_cnt(bit_cnt)
`endif
  );

  prbs_checker #(.ERR_W(4), .UNLOCK_ERRS(15), .GOOD_RUN(1)) dut6 (
    .clk(clk), .RSTn(RSTn), .in_valid(in_valid6), .in_bit(in_bit6), .clr_err(clr_err6),
    .locked(locked6), .err_pulse(err_pulse6), .lock_lost(lock_lost6), .err_cnt(err_cnt6)
`ifdef PRBS_CHK_STATS_EN
    , .bit_cnt(bit_cnt6)
`endif
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference generator: fb = ^(s & taps), s <= {s, fb}, emitted bit is fb.
  logic [3:0] tp = 4'b1100;
  logic [3:0] g  = 4'b0001;
  function automatic bit gen_next();
    bit fb;
    fb = ^(g & tp);
    g  = {g[2:0], fb};
    return fb;
  endfunction

  // Behavioural model: hist[0] is the newest bit (received, or predicted once locked).
  localparam int W = 4, LOCK = 8, UNL = 4, GR = 16, EMAX = 65535;
  bit hist[$];
  int loaded, streak, run, tally, m_err;
  bit verifying, m_locked, m_pulse, m_lost;

  task automatic model_reset();
    hist.delete();
    loaded = 0; streak = 0; run = 0; tally = 0; m_err = 0;
    verifying = 0; m_locked = 0; m_pulse = 0; m_lost = 0;
  endtask

  task automatic hist_push(input bit x);
    hist.push_front(x);
    if (hist.size() > W) void'(hist.pop_back());
  endtask

  function automatic bit model_pred();
    bit p = 0;
    for (int k = 0; k < W; k++) if (tp[k] && k < hist.size()) p ^= hist[k];
    return p;
  endfunction

  function automatic bit hist_nonzero();
    bit nz = 0;
    foreach (hist[k]) nz |= hist[k];
    return nz;
  endfunction

  task automatic model_step(input bit v, input bit b, input bit c);
    bit p;
    m_pulse = 0;
    m_lost  = 0;
    if (v) begin
      p = model_pred();
      if (m_locked) begin
        hist_push(p);
        if (p != b) begin
          m_pulse = 1;
          if (m_err < EMAX) m_err++;
          tally++;
          run = 0;
          if (tally == UNL) begin
            m_locked = 0; m_lost = 1; loaded = 0; tally = 0;
          end
        end else begin
          run++;
          if (run == GR) begin run = 0; tally = 0; end
        end
      end else if (verifying) begin
        hist_push(b);
        if (p == b) begin
          streak++;
          if (streak == LOCK) begin
            verifying = 0; m_locked = 1; run = 0; tally = 0;
          end
        end else begin
          verifying = 0; loaded = 0;
        end
      end else begin
        hist_push(b);
        loaded++;
        if (loaded >= W && hist_nonzero()) begin verifying = 1; streak = 0; end
      end
    end
    if (c) m_err = 0;
  endtask

  int seg_pulses, seg_lost, lost6;

  task automatic beat(input bit v, input bit b, input bit c);
    in_valid = v; in_bit = b; clr_err = c;
    @(posedge clk); #1;
    model_step(v, b, c);
    chk("m_locked", int'(locked), int'(m_locked));
    chk("m_err_pulse", int'(err_pulse), int'(m_pulse));
    chk("m_lock_lost", int'(lock_lost), int'(m_lost));
    chk("m_err_cnt", int'(err_cnt), m_err);
    seg_pulses += int'(err_pulse);
    seg_lost   += int'(lock_lost);
  endtask

  task automatic beat6(input bit v, input bit b);
    in_valid6 = v; in_bit6 = b;
    @(posedge clk); #1;
    lost6 += int'(lock_lost6);
  endtask

  // Reset is asserted between clock edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    in_valid = 0; in_valid6 = 0; clr_err = 0;
    #2 RSTn = 1'b0;
    #1;
    chk("rst_locked", int'(locked), 0);
    chk("rst_err_pulse", int'(err_pulse), 0);
    chk("rst_lock_lost", int'(lock_lost), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst6_locked", int'(locked6), 0);
    chk("rst6_err_pulse", int'(err_pulse6), 0);
    chk("rst6_lock_lost", int'(lock_lost6), 0);
    chk("rst6_err_cnt", int'(err_cnt6), 0);
    model_reset();
    @(posedge clk); #1;
    RSTn = 1'b1;
    g = 4'b0001;
  endtask

  // mode: 0 clean, 1 first bit flipped, 2 constant zero, 3 clean with valid every other clk,
  //       4 one idle clk (clr only), 5 reset
  typedef struct {
    int beats; int mode; bit clr;
    bit exp_locked; int exp_err; int exp_pulses; int exp_lost;
  } vec_t;
  vec_t vecs[20];

  initial begin
    vecs[0]  = '{0,   5, 0, 0, 0, 0, 0};
    vecs[1]  = '{11,  0, 0, 0, 0, 0, 0};
    vecs[2]  = '{1,   0, 0, 1, 0, 0, 0};
    vecs[3]  = '{200, 0, 0, 1, 0, 0, 0};
    vecs[4]  = '{1,   1, 0, 1, 1, 1, 0};
    vecs[5]  = '{20,  0, 0, 1, 1, 0, 0};
    vecs[6]  = '{30,  2, 0, 0, 5, 4, 1};
    vecs[7]  = '{0,   4, 1, 0, 0, 0, 0};
    vecs[8]  = '{40,  0, 0, 1, 0, 0, 0};
    vecs[9]  = '{0,   5, 0, 0, 0, 0, 0};
    vecs[10] = '{8,   0, 0, 0, 0, 0, 0};
    vecs[11] = '{1,   1, 0, 0, 0, 0, 0};
    vecs[12] = '{11,  0, 0, 0, 0, 0, 0};
    vecs[13] = '{1,   0, 0, 1, 0, 0, 0};
    vecs[14] = '{1,   1, 1, 1, 0, 1, 0};
    vecs[15] = '{0,   5, 0, 0, 0, 0, 0};
    vecs[16] = '{11,  3, 0, 0, 0, 0, 0};
    vecs[17] = '{1,   3, 0, 1, 0, 0, 0};
    vecs[18] = '{1,   1, 0, 1, 1, 1, 0};
    vecs[19] = '{0,   4, 1, 1, 0, 0, 0};

    model_reset();
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) begin
      seg_pulses = 0;
      seg_lost   = 0;
      case (vecs[i].mode)
        0: repeat (vecs[i].beats) beat(1'b1, gen_next(), vecs[i].clr);
        1: for (int j = 0; j < vecs[i].beats; j++) beat(1'b1, (j == 0) ^ gen_next(), vecs[i].clr);
        2: repeat (vecs[i].beats) beat(1'b1, 1'b0, vecs[i].clr);
        3: repeat (vecs[i].beats) begin
             beat(1'b1, gen_next(), vecs[i].clr);
             beat(1'b0, 1'b0, vecs[i].clr);
           end
        4: beat(1'b0, 1'b0, vecs[i].clr);
        default: do_reset();
      endcase
      $display("vec %0d mode %0d beats %0d: locked=%0b err_cnt=%0d pulses=%0d lost=%0d",
               i, vecs[i].mode, vecs[i].beats, locked, err_cnt, seg_pulses, seg_lost);
      chk($sformatf("vec%0d_locked", i), int'(locked), int'(vecs[i].exp_locked));
      chk($sformatf("vec%0d_err_cnt", i), int'(err_cnt), vecs[i].exp_err);
      chk($sformatf("vec%0d_pulses", i), seg_pulses, vecs[i].exp_pulses);
      chk($sformatf("vec%0d_lost", i), seg_lost, vecs[i].exp_lost);
    end

    // Random stream with flips, zero bursts, idle gaps and clears, checked every clock.
    do_reset();
    begin
      int zero_burst = 0;
      for (int n = 0; n < 3000; n++) begin
        bit v, b, c;
        int r;
        v = ($urandom % 4) != 0;
        c = ($urandom % 150) == 0;
        b = 1'b0;
        if (v) begin
          r = $urandom % 100;
          b = gen_next();
          if (zero_burst > 0) begin
            b = 1'b0;
            zero_burst--;
          end else if (r < 3) begin
            b = ~b;
          end else if (r == 3) begin
            zero_burst = $urandom_range(5, 30);
          end
        end
        beat(v, b, c);
      end
      $display("random phase: locked=%0b err_cnt=%0d", locked, err_cnt);
    end

    // Second instance: alternating good/bad bits never unlock and err_cnt saturates at 15.
    do_reset();
    lost6 = 0;
    repeat (12) beat6(1'b1, gen_next());
    chk("d6_locked_after_12", int'(locked6), 1);
    repeat (14) begin
      beat6(1'b1, ~gen_next());
      beat6(1'b1, gen_next());
    end
    $display("dut6 after 14 errors: err_cnt=%0d locked=%0b", err_cnt6, locked6);
    chk("d6_err_14", int'(err_cnt6), 14);
    repeat (6) begin
      beat6(1'b1, ~gen_next());
      beat6(1'b1, gen_next());
    end
    $display("dut6 after 20 errors: err_cnt=%0d locked=%0b lost=%0d", err_cnt6, locked6, lost6);
    chk("d6_err_sat", int'(err_cnt6), 15);
    chk("d6_locked_kept", int'(locked6), 1);
    chk("d6_no_lock_lost", lost6, 0);
    beat6(1'b1, ~gen_next());
    chk("d6_pulse_before_rst", int'(err_pulse6), 1);
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
